// File: rtl/clock_pkg.sv
// Shared types and limits for the binary clock counter stages (seconds, minutes, hours).
package clock_pkg;
  typedef logic [5:0] sec_t;

  localparam sec_t SEC_MAX = 6'd59;
  localparam sec_t MIN_MAX = 6'd59;
endpackage

// File: rtl/input_sync.sv
// Two-flop synchronizer for an asynchronous level, with an optional one-cycle rising-edge strobe.
// Latency: sync_o follows the input after 2 edges, rise_o is high in that same cycle; no backpressure.
module input_sync #(
  parameter bit EDGE_EN = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) prev_q <= 1'b0;
        else         prev_q <= sync_q;
      end

      assign rise_o = sync_q & ~prev_q;
    end else begin : g_no_edge
      assign rise_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/seconds_counter.sv
// Seconds stage: divides the board clock to 1 Hz (or FAST_HZ), counts 0-59, flags second 59.
// Latency: inputs act 3 edges after they change; outputs are registered; no backpressure.
module seconds_counter
  import clock_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int FAST_HZ = 60
) (
  input  logic clk_100MHz,
  input  logic reset_n,
  input  logic run,
  input  logic clear,
  input  logic fast,
  output sec_t seconds,
  output logic sec_pulse,
  output logic tick_minutes
);

  localparam int DIV      = CLK_HZ / TICK_HZ;
  localparam int FAST_DIV = CLK_HZ / FAST_HZ;
  localparam int PW       = $clog2(DIV);

  localparam logic [PW-1:0] TC_NORM = PW'(DIV - 1);
  localparam logic [PW-1:0] TC_FAST = PW'(FAST_DIV - 1);

  generate
    if ((CLK_HZ % TICK_HZ) != 0 || (CLK_HZ % FAST_HZ) != 0 ||
        FAST_HZ < TICK_HZ || DIV < 2) begin : g_bad_params
      $error("seconds_counter: CLK_HZ must divide evenly by TICK_HZ and FAST_HZ, FAST_HZ >= TICK_HZ, DIV >= 2");
    end
  endgenerate

  logic run_s, fast_s, clr_evt;
  logic clear_lvl_unused, run_rise_unused, fast_rise_unused;

  input_sync #(.EDGE_EN(1'b0)) u_sync_run (
    .clk_i(clk_100MHz), .rst_ni(reset_n), .async_i(run),
    .sync_o(run_s), .rise_o(run_rise_unused)
  );

  input_sync #(.EDGE_EN(1'b0)) u_sync_fast (
    .clk_i(clk_100MHz), .rst_ni(reset_n), .async_i(fast),
    .sync_o(fast_s), .rise_o(fast_rise_unused)
  );

  input_sync #(.EDGE_EN(1'b1)) u_sync_clear (
    .clk_i(clk_100MHz), .rst_ni(reset_n), .async_i(clear),
    .sync_o(clear_lvl_unused), .rise_o(clr_evt)
  );

  logic [PW-1:0] presc_q, presc_d;
  sec_t          sec_q, sec_d, sec_nxt;
  logic          pulse_q, pulse_d;
  logic          tick_q, tick_d;
  logic [PW-1:0] tc;

  assign tc = fast_s ? TC_FAST : TC_NORM;

  // The >= compare lets a fast->normal or normal->fast switch land safely at any prescaler value.
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    pulse_d = 1'b0;
    tick_d  = tick_q;
    sec_nxt = (sec_q == SEC_MAX) ? 6'd0 : sec_q + 6'd1;
    if (clr_evt) begin
      presc_d = '0;
      sec_d   = '0;
      tick_d  = 1'b0;
    end else if (run_s) begin
      if (presc_q >= tc) begin
        presc_d = '0;
        pulse_d = 1'b1;
        sec_d   = sec_nxt;
        tick_d  = (sec_nxt == SEC_MAX);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      sec_q   <= '0;
      pulse_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      pulse_q <= pulse_d;
      tick_q  <= tick_d;
    end
  end

  assign seconds      = sec_q;
  assign sec_pulse    = pulse_q;
  assign tick_minutes = tick_q;

endmodule

// File: tb/tb_seconds_counter.sv
// Scoreboard bench for seconds_counter with DIV=10, FAST_DIV=2.
// Each expected strobe carries the clock edge it must land on, plus seconds and tick_minutes.
module tb_seconds_counter;

  logic       clk_100MHz;
  logic       reset_n;
  logic       run;
  logic       clear;
  logic       fast;
  logic [5:0] seconds;
  logic       sec_pulse;
  logic       tick_minutes;

  seconds_counter #(.CLK_HZ(10), .TICK_HZ(1), .FAST_HZ(5)) dut (
    .clk_100MHz  (clk_100MHz),
    .reset_n     (reset_n),
    .run         (run),
    .clear       (clear),
    .fast        (fast),
    .seconds     (seconds),
    .sec_pulse   (sec_pulse),
    .tick_minutes(tick_minutes)
  );

  typedef struct {
    int edge_no;
    int sec;
    int tick;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   edge_cnt    = 0;
  int   tick_hi_cnt = 0;
  int   chk_cnt     = 0;
  int   err_cnt     = 0;

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  always @(posedge clk_100MHz) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input int act, input int exp);
    chk_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, act, exp, edge_cnt);
    end
  endtask

  task automatic push_exp(input int e, input int s, input int t);
    exp_t x;
    x.edge_no = e;
    x.sec     = s;
    x.tick    = t;
    exp_q.push_back(x);
  endtask

  // Leaves the caller 1 time unit after a falling edge, well clear of the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_100MHz);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int left;
    left = budget;
    while (exp_q.size() > 0) begin
      if (left == 0) begin
        chk("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        break;
      end
      step(1);
      left--;
    end
  endtask

  always @(negedge clk_100MHz) begin
    if (sec_pulse === 1'b1) begin
      chk("pulse_expected", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("pulse_edge", edge_cnt, mon_e.edge_no);
        chk("pulse_sec", int'(seconds), mon_e.sec);
        chk("pulse_tick", int'(tick_minutes), mon_e.tick);
      end
    end
    if (tick_minutes === 1'b1) tick_hi_cnt++;
  end

  initial begin
    int k, p, r, c, d, f, g, h;
    reset_n = 1'b1;
    run     = 1'b0;
    clear   = 1'b0;
    fast    = 1'b0;
    #1 reset_n = 1'b0;
    step(3);
    chk("rst_seconds", int'(seconds), 0);
    chk("rst_pulse", int'(sec_pulse), 0);
    chk("rst_tick", int'(tick_minutes), 0);

    // Full minute at the normal rate.
    tick_hi_cnt = 0;
    reset_n = 1'b1;
    run     = 1'b1;
    k = edge_cnt;
    for (int i = 1; i <= 60; i++) push_exp(k + 2 + 10 * i, i % 60, (i == 59) ? 1 : 0);
    drain(700);
    chk("tick_hi_cycles", tick_hi_cnt, 10);
    chk("wrap_seconds", int'(seconds), 0);

    // Pause with the prescaler at 4 and seconds at 7.
    p = edge_cnt;
    for (int s = 1; s <= 7; s++) push_exp(p + 10 * s, s, 0);
    drain(100);
    step(2);
    run = 1'b0;
    step(10);
    chk("pause_sec_early", int'(seconds), 7);
    step(40);
    chk("pause_sec_late", int'(seconds), 7);
    chk("pause_tick", int'(tick_minutes), 0);
    r = edge_cnt;
    run = 1'b1;
    push_exp(r + 8, 8, 0);
    drain(30);

    // Clear held high: one event only, counting restarts underneath it.
    c = edge_cnt;
    clear = 1'b1;
    push_exp(c + 13, 1, 0);
    push_exp(c + 23, 2, 0);
    step(3);
    chk("clr_seconds", int'(seconds), 0);
    chk("clr_pulse", int'(sec_pulse), 0);
    step(17);
    clear = 1'b0;
    drain(30);

    // Clear lands on the edge that would have wrapped 59 -> 0.
    c = edge_cnt;
    for (int s = 3; s <= 59; s++) push_exp(c + 10 * (s - 2), s, (s == 59) ? 1 : 0);
    drain(700);
    chk("pre_clr_tick", int'(tick_minutes), 1);
    step(7);
    d = edge_cnt;
    clear = 1'b1;
    push_exp(d + 13, 1, 0);
    step(3);
    chk("clr59_seconds", int'(seconds), 0);
    chk("clr59_tick", int'(tick_minutes), 0);
    chk("clr59_pulse", int'(sec_pulse), 0);
    step(2);
    clear = 1'b0;
    drain(30);

    // Fast mode from seconds 0, then back to normal with the prescaler at 1.
    f = edge_cnt;
    clear = 1'b1;
    fast  = 1'b1;
    for (int s = 1; s <= 59; s++) push_exp(f + 3 + 2 * s, s, (s == 59) ? 1 : 0);
    push_exp(f + 131, 0, 0);
    step(5);
    clear = 1'b0;
    step(115);
    fast = 1'b0;
    drain(40);

    // Asynchronous reset between edges at seconds 33.
    g = edge_cnt;
    for (int s = 1; s <= 33; s++) push_exp(g + 10 * s, s, 0);
    drain(400);
    chk("pre_rst_seconds", int'(seconds), 33);
    step(4);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_seconds", int'(seconds), 0);
    chk("arst_pulse", int'(sec_pulse), 0);
    chk("arst_tick", int'(tick_minutes), 0);
    step(3);
    reset_n = 1'b1;
    h = edge_cnt;
    push_exp(h + 12, 1, 0);
    push_exp(h + 22, 2, 0);
    drain(40);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/seconds_counter.md
# seconds_counter

Seconds stage of the binary clock. Divides the board clock down to 1 Hz, counts seconds 0–59, and drives `tick_minutes` into the minutes counter, which advances on that signal's falling edge. Also provides run/pause, synchronous clear, and a fast-advance mode for setting the time. All inputs arrive from board switches/buttons and are asynchronous.

## Interface
- `CLK_HZ`, 100_000_000, board clock frequency.
- `TICK_HZ`, 1, normal seconds rate; `DIV = CLK_HZ/TICK_HZ`.
- `FAST_HZ`, 60, seconds rate while `fast` is high; `FAST_DIV = CLK_HZ/FAST_HZ`.
- `clk_100MHz`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  async level; 1 = count, 0 = hold.
- `clear`  in  1  async button; rising edge zeroes the counter.
- `fast`  in  1  async level; selects `FAST_DIV`.
- `seconds`  out  6  current second, 0–59, registered.
- `sec_pulse`  out  1  one-cycle strobe per seconds increment, registered.
- `tick_minutes`  out  1  registered level, high exactly while `seconds == 59`.

## Operation
- Reset (`reset_n` low, asynchronous): prescaler = 0, `seconds` = 0, `sec_pulse` = 0, `tick_minutes` = 0, all synchronizer flops = 0.
- `run`, `clear`, `fast`: each passes through a 2-flop synchronizer. `clear` is also rising-edge detected on the synchronized value, giving a one-cycle `clr_evt`.
- Terminal count `tc` is `FAST_DIV-1` when synchronized fast = 1, otherwise `DIV-1`.
- Priority on each rising clock edge:
  1. `clr_evt`: prescaler ← 0, `seconds` ← 0, `tick_minutes` ← 0, `sec_pulse` ← 0. This overrides any simultaneous tick.
  2. Else if run = 0: all state holds, `sec_pulse` ← 0.
  3. Else if prescaler ≥ `tc`: prescaler ← 0, `sec_pulse` ← 1, `seconds` ← (59 → 0, otherwise +1), `tick_minutes` ← (next seconds == 59).
  4. Else: prescaler ← prescaler + 1, `sec_pulse` ← 0.
- The ≥ comparison is required. When `fast` drops while the prescaler is above the fast terminal count, the normal count simply continues. When `fast` rises while the prescaler is above `FAST_DIV-1`, the counter wraps on the next cycle. The counter never runs away.
- Wrap: 59 → 0 happens on a `sec_pulse` edge. `tick_minutes` falls on that same edge, which is the downstream minutes increment.
- Clear at `seconds == 59` drops `tick_minutes` and advances the minutes stage by one. This is accepted, documented behaviour.
- Widths: prescaler is `$clog2(DIV)` bits. `seconds` arithmetic is 6-bit and never exceeds 59.
- Elaboration checks: `CLK_HZ % TICK_HZ == 0`, `CLK_HZ % FAST_HZ == 0`, `FAST_HZ ≥ TICK_HZ`, `DIV ≥ 2`.

## Timing
- Input latency: 2 cycles of synchronization. The `clear` effect is visible 3 edges after the input rises.
- With run continuously high, the period between `sec_pulse` strobes is exactly `DIV` cycles (`FAST_DIV` in fast mode).
- `seconds` and `sec_pulse` update on the same edge.
- `tick_minutes` is high for exactly one seconds period (`DIV` cycles) per minute. It never glitches, since it is a flop output.
- Pausing (run low) freezes the prescaler mid-count. Resuming continues from the stored value with no phase loss.
- Reset mid-count: outputs go to 0 immediately, without waiting for a clock. Counting restarts from prescaler 0 after reset is released.

## Structure
- Shared package `clock_pkg`:
  - `SEC_MAX = 59` and `MIN_MAX = 59`, also used by the minutes and hours stages.
  - Typedef `sec_t` = logic [5:0].
- Sub-module `input_sync`: 2-flop synchronizer with optional rising-edge output, instantiated three times.
- The prescaler and seconds counter stay in the top module.

## Test plan
All scenarios use `CLK_HZ=10`, `TICK_HZ=1`, `FAST_HZ=5` (`DIV=10`, `FAST_DIV=2`).
1. Reset then run = 1 for 600 cycles:
   - `seconds` steps 0→59→0.
   - `sec_pulse` every 10 cycles, 60 pulses total.
   - `tick_minutes` high for exactly 10 cycles, falling as `seconds` becomes 0.
2. run = 0 at prescaler 4, `seconds` 7, held 50 cycles, then run = 1:
   - no change while paused.
   - next `sec_pulse` exactly 6 cycles (plus sync latency) after resume.
3. fast = 1 from `seconds` 0:
   - `sec_pulse` every 2 cycles.
   - `seconds` reaches 59 after 118 cycles.
   - switching fast low at prescaler 1 gives the next pulse 9 cycles later.
4. `clear` rising on the same edge as a scheduled tick at `seconds` 59:
   - `seconds` = 0, `tick_minutes` = 0, no `sec_pulse`.
   - prescaler restarts, next pulse after 10 cycles.
5. `reset_n` pulsed low asynchronously mid-count (`seconds` 33, between clock edges):
   - all outputs read 0 before the next edge.
   - counting resumes from prescaler 0 after release.
6. Hold `clear` high for 20 cycles:
   - only one clear event.
   - counting resumes while `clear` is still held high.
